// File: rtl/mips_mult_div_pkg.sv
// Shared definitions for the MIPS multiply/divide unit: op encodings,
// FSM state encoding and the iteration counter sizing helper.
package mips_mult_div_pkg;

  typedef enum logic [1:0] {
    MD_MULTU = 2'b00,
    MD_MULT  = 2'b01,
    MD_DIVU  = 2'b10,
    MD_DIV   = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_FIN  = 2'b10
  } md_state_e;

  localparam int MD_DEFAULT_WIDTH = 32;

  // Counter must reach WIDTH-1, so $clog2(WIDTH) bits; never narrower than 1.
  function automatic int md_cnt_width(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/mips_mult_div_datapath.sv
// Iteration datapath of the multiply/divide unit.
// Multiply: radix-2 shift-add; {acc, shreg} ends up as the 2*WIDTH-bit product.
// Divide: restoring division; shreg ends as the quotient, acc as the remainder.
// Operands arrive here already as magnitudes; sign handling lives in the top.
import mips_mult_div_pkg::*;

module mips_mult_div_datapath #(
  parameter int WIDTH = MD_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             step,
  input  logic             is_div,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic [WIDTH-1:0] acc,
  output logic [WIDTH-1:0] shreg
);

  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [WIDTH-1:0] b_q, b_d;

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH-1:0] div_diff;
  logic             div_fits;

  // One iteration's worth of arithmetic for both operations.
  always_comb begin
    mul_sum   = {1'b0, acc_q} + (sh_q[0] ? {1'b0, b_q} : {(WIDTH+1){1'b0}});
    div_shift = {acc_q, sh_q[WIDTH-1]};
    div_diff  = div_shift[WIDTH-1:0] - b_q;
    div_fits  = div_shift[WIDTH] | (div_shift[WIDTH-1:0] >= b_q);
  end

  // Load clears the accumulator and seeds the shift register; step advances one bit.
  always_comb begin
    acc_d = acc_q;
    sh_d  = sh_q;
    b_d   = b_q;
    if (load) begin
      acc_d = '0;
      sh_d  = op_a;
      b_d   = op_b;
    end else if (step) begin
      if (is_div) begin
        if (div_fits) begin
          acc_d = div_diff;
          sh_d  = {sh_q[WIDTH-2:0], 1'b1};
        end else begin
          acc_d = div_shift[WIDTH-1:0];
          sh_d  = {sh_q[WIDTH-2:0], 1'b0};
        end
      end else begin
        acc_d = mul_sum[WIDTH:1];
        sh_d  = {mul_sum[0], sh_q[WIDTH-1:1]};
      end
    end
  end

  // Work registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      sh_q  <= '0;
      b_q   <= '0;
    end else begin
      acc_q <= acc_d;
      sh_q  <= sh_d;
      b_q   <= b_d;
    end
  end

  assign acc   = acc_q;
  assign shreg = sh_q;

endmodule

// File: rtl/mips_mult_div.sv
// MIPS multiply/divide unit with architectural HI/LO registers.
// Keeps the FSM, operand latching, sign fix-up and HI/LO with MTHI/MTLO.
// Optional macro SIGNED_MD_EN: when defined, MULT/DIV are signed; otherwise
// they behave as MULTU/DIVU and no sign logic is built.
import mips_mult_div_pkg::*;

module mips_mult_div #(
  parameter int WIDTH = MD_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero
);

  localparam int             CW       = md_cnt_width(WIDTH);
  localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH-1);

  md_state_e        state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             is_div_q, is_div_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic             b_zero_q, b_zero_d;
  logic             done_q, done_d;
  logic             dbz_q, dbz_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  logic             op_is_div;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic             dp_load, dp_step;
  logic [WIDTH-1:0] dp_acc, dp_sh;

  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quot, rem;
  logic [WIDTH-1:0]   res_hi, res_lo;

`ifdef SIGNED_MD_EN
  logic op_is_signed;
  logic signed_q, signed_d;
  logic sign_a_q, sign_a_d;
  logic sign_b_q, sign_b_d;
`endif

  // Decode the incoming op and turn signed operands into magnitudes.
  always_comb begin
    op_is_div = (md_op_e'(op) == MD_DIVU) || (md_op_e'(op) == MD_DIV);
    mag_a     = operand_a;
    mag_b     = operand_b;
`ifdef SIGNED_MD_EN
    op_is_signed = (md_op_e'(op) == MD_MULT) || (md_op_e'(op) == MD_DIV);
    if (op_is_signed && operand_a[WIDTH-1]) mag_a = -operand_a;
    if (op_is_signed && operand_b[WIDTH-1]) mag_b = -operand_b;
`endif
  end

  // Apply result signs and the divide-by-zero override to the raw datapath result.
  always_comb begin
    prod = {dp_acc, dp_sh};
    quot = dp_sh;
    rem  = dp_acc;
`ifdef SIGNED_MD_EN
    if (signed_q) begin
      if (sign_a_q ^ sign_b_q) begin
        prod = -prod;
        quot = -quot;
      end
      if (sign_a_q) rem = -rem;
    end
`endif
    if (is_div_q) begin
      if (b_zero_q) begin
        res_hi = a_q;
        res_lo = '1;
      end else begin
        res_hi = rem;
        res_lo = quot;
      end
    end else begin
      res_hi = prod[2*WIDTH-1:WIDTH];
      res_lo = prod[WIDTH-1:0];
    end
  end

  // Next-state and control: launch in IDLE, iterate in RUN, commit HI/LO in FIN.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    is_div_d = is_div_q;
    a_d      = a_q;
    b_zero_d = b_zero_q;
    done_d   = 1'b0;
    dbz_d    = dbz_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    dp_load  = 1'b0;
    dp_step  = 1'b0;
`ifdef SIGNED_MD_EN
    signed_d = signed_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_RUN;
          cnt_d    = CNT_LAST;
          is_div_d = op_is_div;
          a_d      = operand_a;
          b_zero_d = (operand_b == '0);
          dbz_d    = 1'b0;
          dp_load  = 1'b1;
`ifdef SIGNED_MD_EN
          signed_d = op_is_signed;
          sign_a_d = op_is_signed & operand_a[WIDTH-1];
          sign_b_d = op_is_signed & operand_b[WIDTH-1];
`endif
        end else begin
          if (hi_we) hi_d = wdata;
          if (lo_we) lo_d = wdata;
        end
      end
      S_RUN: begin
        dp_step = 1'b1;
        if (cnt_q == '0) state_d = S_FIN;
        else             cnt_d   = cnt_q - CW'(1);
      end
      S_FIN: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
        hi_d    = res_hi;
        lo_d    = res_lo;
        if (is_div_q && b_zero_q) dbz_d = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control and architectural state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      a_q      <= '0;
      b_zero_q <= 1'b0;
      done_q   <= 1'b0;
      dbz_q    <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
      a_q      <= a_d;
      b_zero_q <= b_zero_d;
      done_q   <= done_d;
      dbz_q    <= dbz_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

`ifdef SIGNED_MD_EN
  // Operand signs captured at launch for the FIN fix-up.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      signed_q <= 1'b0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
    end else begin
      signed_q <= signed_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
    end
  end
`endif

  mips_mult_div_datapath #(
    .WIDTH (WIDTH)
  ) u_datapath (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (dp_load),
    .step   (dp_step),
    .is_div (is_div_q),
    .op_a   (mag_a),
    .op_b   (mag_b),
    .acc    (dp_acc),
    .shreg  (dp_sh)
  );

  assign busy        = (state_q != S_IDLE);
  assign done        = done_q;
  assign hi          = hi_q;
  assign lo          = lo_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_mips_mult_div.sv
// Directed self-checking bench for mips_mult_div (WIDTH=32).
// Signed expectations are used when SIGNED_MD_EN is defined, unsigned otherwise.
import mips_mult_div_pkg::*;

module tb_mips_mult_div;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic        hi_we;
  logic        lo_we;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        div_by_zero;

  int checks = 0;
  int errors = 0;
  int cycles;
  logic [31:0] expHi;

  mips_mult_div #(.WIDTH(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .op          (op),
    .operand_a   (operand_a),
    .operand_b   (operand_b),
    .hi_we       (hi_we),
    .lo_we       (lo_we),
    .wdata       (wdata),
    .busy        (busy),
    .done        (done),
    .hi          (hi),
    .lo          (lo),
    .div_by_zero (div_by_zero)
  );

  // Free-running clock, 10 ns period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports any mismatch.
  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Present one op with start for exactly one edge (T0); returns at T0+#1.
  task automatic applyStimulus(input md_op_e o, input logic [31:0] a, input logic [31:0] b);
    op        = o;
    operand_a = a;
    operand_b = b;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Count edges until done, bounded; the done check itself flags a timeout.
  task automatic waitDone(input string tag, output int n);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!done && n < 100);
    checkOutput({tag, "_done"}, {63'd0, done}, 64'd1);
  endtask

  // Full op: launch, wait, check latency and HI/LO.
  task automatic runOp(input string tag, input md_op_e o, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] eHi, input logic [31:0] eLo);
    int n;
    applyStimulus(o, a, b);
    waitDone(tag, n);
    checkOutput({tag, "_lat"}, 64'(n), 64'd33);
    checkOutput({tag, "_hi"}, {32'd0, hi}, {32'd0, eHi});
    checkOutput({tag, "_lo"}, {32'd0, lo}, {32'd0, eLo});
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; op = 2'b00; operand_a = '0; operand_b = '0;
    hi_we = 1'b0; lo_we = 1'b0; wdata = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_busy", {63'd0, busy}, 64'd0);
    checkOutput("rst_done", {63'd0, done}, 64'd0);
    checkOutput("rst_hi", {32'd0, hi}, 64'd0);
    checkOutput("rst_lo", {32'd0, lo}, 64'd0);
    checkOutput("rst_dbz", {63'd0, div_by_zero}, 64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] test 1: MULTU max*max");
    runOp("t1", MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    checkOutput("t1_busy_at_done", {63'd0, busy}, 64'd0);
    @(posedge clk);
    #1;
    checkOutput("t1_done_pulse", {63'd0, done}, 64'd0);

    $display("[TB] test 2: DIVU and divide by zero");
    runOp("t2a", MD_DIVU, 32'd100, 32'd7, 32'd2, 32'd14);
    checkOutput("t2a_dbz", {63'd0, div_by_zero}, 64'd0);
    runOp("t2b", MD_DIVU, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF);
    checkOutput("t2b_dbz", {63'd0, div_by_zero}, 64'd1);
    applyStimulus(MD_MULTU, 32'd7, 32'd8);
    checkOutput("t2c_dbz_clr", {63'd0, div_by_zero}, 64'd0);
    checkOutput("t2c_busy", {63'd0, busy}, 64'd1);
    checkOutput("t2c_hi_hold", {32'd0, hi}, 64'd5);
    waitDone("t2c", cycles);
    checkOutput("t2c_lo", {32'd0, lo}, 64'd56);

    $display("[TB] test 3: op 01/11");
`ifdef SIGNED_MD_EN
    runOp("t3a", MD_MULT, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
    runOp("t3b", MD_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    runOp("t3c", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
    runOp("t3d", MD_DIV, 32'hFFFF_FFF7, 32'd0, 32'hFFFF_FFF7, 32'hFFFF_FFFF);
    expHi = 32'hFFFF_FFF7;
`else
    runOp("t3a", MD_MULT, 32'hFFFF_FFFD, 32'd5, 32'h0000_0004, 32'hFFFF_FFF1);
    runOp("t3b", MD_DIV, 32'hFFFF_FFF9, 32'd2, 32'h0000_0001, 32'h7FFF_FFFC);
    runOp("t3c", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0000);
    runOp("t3d", MD_DIV, 32'h0000_0009, 32'd0, 32'h0000_0009, 32'hFFFF_FFFF);
    expHi = 32'h0000_0009;
`endif
    checkOutput("t3d_dbz", {63'd0, div_by_zero}, 64'd1);

    $display("[TB] test 4: start and MTHI while busy");
    applyStimulus(MD_MULTU, 32'd3, 32'd4);
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    operand_a = 32'd9;
    operand_b = 32'd9;
    start     = 1'b1;
    hi_we     = 1'b1;
    wdata     = 32'hDEAD_BEEF;
    @(posedge clk);
    #1;
    start = 1'b0;
    hi_we = 1'b0;
    checkOutput("t4_busy", {63'd0, busy}, 64'd1);
    checkOutput("t4_hi_hold", {32'd0, hi}, {32'd0, expHi});
    waitDone("t4", cycles);
    checkOutput("t4_lat", 64'(cycles), 64'd28);
    checkOutput("t4_hi", {32'd0, hi}, 64'd0);
    checkOutput("t4_lo", {32'd0, lo}, 64'd12);
    @(posedge clk);
    #1;
    checkOutput("t4_no_requeue", {63'd0, busy}, 64'd0);

    $display("[TB] test 5: MTLO/MTHI in idle");
    lo_we = 1'b1;
    wdata = 32'h0000_1234;
    @(posedge clk);
    #1;
    lo_we = 1'b0;
    checkOutput("t5_lo_wr", {32'd0, lo}, 64'h1234);
    checkOutput("t5_hi_keep", {32'd0, hi}, 64'd0);
    hi_we = 1'b1;
    lo_we = 1'b1;
    wdata = 32'h0000_ABCD;
    @(posedge clk);
    #1;
    hi_we = 1'b0;
    lo_we = 1'b0;
    checkOutput("t5_both_hi", {32'd0, hi}, 64'hABCD);
    checkOutput("t5_both_lo", {32'd0, lo}, 64'hABCD);
    lo_we = 1'b1;
    wdata = 32'h0000_5555;
    applyStimulus(MD_MULTU, 32'd2, 32'd3);
    lo_we = 1'b0;
    checkOutput("t5_drop_lo", {32'd0, lo}, 64'hABCD);
    waitDone("t5", cycles);
    checkOutput("t5_res_hi", {32'd0, hi}, 64'd0);
    checkOutput("t5_res_lo", {32'd0, lo}, 64'd6);

    $display("[TB] test 6: async reset mid-op");
    applyStimulus(MD_DIVU, 32'd1000, 32'd3);
    repeat (9) begin
      @(posedge clk);
      #1;
    end
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("t6_busy", {63'd0, busy}, 64'd0);
    checkOutput("t6_done", {63'd0, done}, 64'd0);
    checkOutput("t6_hi", {32'd0, hi}, 64'd0);
    checkOutput("t6_lo", {32'd0, lo}, 64'd0);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done) checkOutput("t6_stray_done", {63'd0, done}, 64'd0);
    end
    runOp("t6b", MD_MULTU, 32'd6, 32'd7, 32'd0, 32'd42);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
